// File: rtl/floo_rsp_last_tracker_pkg.sv
// Shared types and helpers for the response last-beat tracker.
// The optional error mode is controlled by FLOO_RSP_LAST_TRACKER_ERR_EN.
package floo_rsp_last_tracker_pkg;

    // Classification of what happens on the response side in one cycle.
    typedef enum logic [1:0] {
        BEAT_NONE  = 2'd0,
        BEAT_MID   = 2'd1,
        BEAT_LAST  = 2'd2,
        BEAT_STRAY = 2'd3
    } beat_kind_e;

    // A stray beat (arrived with nothing outstanding) dominates any handshake.
    function automatic beat_kind_e classify_beat(
        input logic handshake,
        input logic last,
        input logic stray
    );
        beat_kind_e kind;
        if (stray) begin
            kind = BEAT_STRAY;
        end else if (!handshake) begin
            kind = BEAT_NONE;
        end else if (last) begin
            kind = BEAT_LAST;
        end else begin
            kind = BEAT_MID;
        end
        return kind;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Port-compatible fifo_v3 (common_cells style): registered occupancy,
// power-of-two depth, optional fall-through, synchronous flush.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);
    localparam int unsigned CNT_W = ADDR_DEPTH + 1;

    logic [ADDR_DEPTH-1:0] read_ptr_r;
    logic [ADDR_DEPTH-1:0] write_ptr_r;
    logic [CNT_W-1:0]      status_cnt_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic stored_empty_s;
    logic push_eff_s;
    logic pop_eff_s;
    logic bypass_s;
    logic store_s;
    logic load_s;
    logic unused_testmode_s;

    assign unused_testmode_s = testmode_i;

    assign stored_empty_s = (status_cnt_r == {CNT_W{1'b0}});
    assign full_o         = (status_cnt_r == CNT_W'(DEPTH));
    assign empty_o        = stored_empty_s & ~(FALL_THROUGH & push_i);
    assign usage_o        = status_cnt_r[ADDR_DEPTH-1:0];

    assign push_eff_s = push_i & ~full_o;
    assign pop_eff_s  = pop_i & ~empty_o;
    // In fall-through mode an entry pushed and popped into an empty FIFO never lands in memory.
    assign bypass_s   = FALL_THROUGH & stored_empty_s & push_eff_s & pop_eff_s;
    assign store_s    = push_eff_s & ~bypass_s;
    assign load_s     = pop_eff_s & ~bypass_s;

    // Output data selection, including the fall-through path.
    always_comb begin
        data_o = mem_r[read_ptr_r];
        if (FALL_THROUGH && stored_empty_s && push_i) begin
            data_o = data_i;
        end else begin
            data_o = mem_r[read_ptr_r];
        end
    end

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            read_ptr_r   <= {ADDR_DEPTH{1'b0}};
            write_ptr_r  <= {ADDR_DEPTH{1'b0}};
            status_cnt_r <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (flush_i) begin
            read_ptr_r   <= {ADDR_DEPTH{1'b0}};
            write_ptr_r  <= {ADDR_DEPTH{1'b0}};
            status_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (store_s) begin
                mem_r[write_ptr_r] <= data_i;
                write_ptr_r        <= write_ptr_r + ADDR_DEPTH'(1);
            end
            if (load_s) begin
                read_ptr_r <= read_ptr_r + ADDR_DEPTH'(1);
            end
            case ({store_s, load_s})
                2'b10:   status_cnt_r <= status_cnt_r + CNT_W'(1);
                2'b01:   status_cnt_r <= status_cnt_r - CNT_W'(1);
                default: status_cnt_r <= status_cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/floo_rsp_last_tracker.sv
// Tracks burst lengths of in-flight requests and marks the last response beat.
// Define FLOO_RSP_LAST_TRACKER_ERR_EN to drop stray beats and flag them on err_o.
module floo_rsp_last_tracker
    import floo_rsp_last_tracker_pkg::*;
#(
    parameter int unsigned Depth     = 8,
    parameter int unsigned LenWidth  = 8,
    parameter int unsigned DataWidth = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       ax_valid_i,
    output logic                       ax_ready_o,
    input  logic [LenWidth-1:0]        ax_len_i,
    output logic                       ax_valid_o,
    input  logic                       ax_ready_i,
    input  logic                       rsp_valid_i,
    output logic                       rsp_ready_o,
    input  logic [DataWidth-1:0]       rsp_data_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [DataWidth-1:0]       rsp_data_o,
    output logic                       rsp_last_o,
    output logic [$clog2(Depth+1)-1:0] outstanding_o,
    output logic                       err_o
);
    localparam int unsigned CntWidth  = $clog2(Depth + 1);
    localparam int unsigned AddrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic                 full_s;
    logic                 empty_s;
    logic [AddrWidth-1:0] usage_s;
    logic [LenWidth-1:0]  head_len_s;
    logic [LenWidth-1:0]  beat_cnt_r;
    logic                 push_s;
    logic                 pop_s;
    logic                 beat_hs_s;
    logic                 stray_s;
    beat_kind_e           kind_s;

    // Request gating sees only registered FIFO state, so a pop never frees a slot in the same cycle.
    assign ax_valid_o = ax_valid_i & ~full_s;
    assign ax_ready_o = ax_ready_i & ~full_s;
    assign push_s     = ax_valid_o & ax_ready_i;

    assign rsp_valid_o = rsp_valid_i & ~empty_s;
    assign rsp_data_o  = rsp_data_i;
    assign rsp_last_o  = ~empty_s & (beat_cnt_r == head_len_s);
    assign beat_hs_s   = rsp_valid_o & rsp_ready_i;
    assign pop_s       = beat_hs_s & rsp_last_o;

`ifdef FLOO_RSP_LAST_TRACKER_ERR_EN
    assign rsp_ready_o = empty_s ? 1'b1 : rsp_ready_i;
    assign stray_s     = rsp_valid_i & empty_s;
`else
    assign rsp_ready_o = rsp_ready_i & ~empty_s;
    assign stray_s     = 1'b0;
`endif

    assign kind_s = classify_beat(beat_hs_s, rsp_last_o, stray_s);

    assign outstanding_o = full_s ? CntWidth'(Depth) : CntWidth'(usage_s);

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (LenWidth),
        .DEPTH        (Depth)
    ) i_len_fifo (
        .clk_i      (clk_i),
        .rst_ni     (~rst_i),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (full_s),
        .empty_o    (empty_s),
        .usage_o    (usage_s),
        .data_i     (ax_len_i),
        .push_i     (push_s),
        .data_o     (head_len_s),
        .pop_i      (pop_s)
    );

    // Beat counter within the head burst; wraps naturally at len = 2^LenWidth-1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt_r <= {LenWidth{1'b0}};
        end else begin
            case (kind_s)
                BEAT_MID:   beat_cnt_r <= beat_cnt_r + LenWidth'(1);
                BEAT_LAST:  beat_cnt_r <= {LenWidth{1'b0}};
                BEAT_NONE:  beat_cnt_r <= beat_cnt_r;
                BEAT_STRAY: beat_cnt_r <= beat_cnt_r;
                default:    beat_cnt_r <= beat_cnt_r;
            endcase
        end
    end

`ifdef FLOO_RSP_LAST_TRACKER_ERR_EN
    logic err_r;

    // Sticky flag for beats that arrived with no transaction outstanding.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if (kind_s == BEAT_STRAY) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err_o = err_r;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_floo_rsp_last_tracker.sv
// Directed and randomized bench for floo_rsp_last_tracker against a queue-based model.
module tb_floo_rsp_last_tracker;
    localparam int Depth     = 8;
    localparam int LenWidth  = 8;
    localparam int DataWidth = 64;
    localparam int CntW      = $clog2(Depth + 1);

    logic                 clk;
    logic                 rst_i;
    logic                 ax_valid_i;
    logic                 ax_ready_o;
    logic [LenWidth-1:0]  ax_len_i;
    logic                 ax_valid_o;
    logic                 ax_ready_i;
    logic                 rsp_valid_i;
    logic                 rsp_ready_o;
    logic [DataWidth-1:0] rsp_data_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [DataWidth-1:0] rsp_data_o;
    logic                 rsp_last_o;
    logic [CntW-1:0]      outstanding_o;
    logic                 err_o;

    floo_rsp_last_tracker #(
        .Depth     (Depth),
        .LenWidth  (LenWidth),
        .DataWidth (DataWidth)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .ax_valid_i    (ax_valid_i),
        .ax_ready_o    (ax_ready_o),
        .ax_len_i      (ax_len_i),
        .ax_valid_o    (ax_valid_o),
        .ax_ready_i    (ax_ready_i),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_ready_o   (rsp_ready_o),
        .rsp_data_i    (rsp_data_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .rsp_last_o    (rsp_last_o),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

`ifdef FLOO_RSP_LAST_TRACKER_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: queue of outstanding burst lengths plus beats already delivered for the head.
    int q[$];
    int beats_done;
    bit model_err;
    int passes;
    int total;
    int hs_seen;
    int last_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic idle();
        ax_valid_i  = 1'b0;
        ax_ready_i  = 1'b0;
        ax_len_i    = 8'd0;
        rsp_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
    endtask

    task automatic model_clear();
        q.delete();
        beats_done = 0;
        model_err  = 1'b0;
    endtask

    // Called at posedge+1 with inputs driven; checks outputs, then advances model at the edge.
    task automatic cycle();
        bit full;
        bit empty;
        bit last;
        bit exp_rready;
        rsp_data_i = {$urandom, $urandom};
        #3;
        full  = (q.size() == Depth);
        empty = (q.size() == 0);
        last  = 1'b0;
        if (!empty) last = (beats_done == q[0]);
        exp_rready = ErrEn ? (empty | rsp_ready_i) : (rsp_ready_i & !empty);
        chk("ax_valid_o", ax_valid_o, ax_valid_i & !full);
        chk("ax_ready_o", ax_ready_o, ax_ready_i & !full);
        chk("rsp_valid_o", rsp_valid_o, rsp_valid_i & !empty);
        chk("rsp_ready_o", rsp_ready_o, exp_rready);
        chk("rsp_last_o", rsp_last_o, last);
        chk("rsp_data_o", rsp_data_o, rsp_data_i);
        chk("outstanding_o", outstanding_o, q.size());
        chk("err_o", err_o, model_err);
        if (rsp_valid_o && rsp_ready_i) begin
            hs_seen++;
            if (rsp_last_o) last_seen++;
        end
        @(posedge clk);
        if (rsp_valid_i && rsp_ready_i && !empty) begin
            if (last) begin
                void'(q.pop_front());
                beats_done = 0;
            end else begin
                beats_done++;
            end
        end
        if (ErrEn && rsp_valid_i && empty) model_err = 1'b1;
        if (ax_valid_i && ax_ready_i && !full) q.push_back(int'(ax_len_i));
        #1;
    endtask

    task automatic push_req(input int len);
        idle();
        ax_valid_i = 1'b1;
        ax_ready_i = 1'b1;
        ax_len_i   = LenWidth'(len);
        cycle();
        idle();
    endtask

    task automatic drain(input string tag);
        idle();
        rsp_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 400 && q.size() > 0; i++) cycle();
        idle();
        #2;
        chk(tag, outstanding_o, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        passes = 0;
        total  = 0;
        model_clear();
        idle();
        rst_i      = 1'b1;
        rsp_data_i = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outstanding", outstanding_o, 0);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_rsp_last", rsp_last_o, 0);
        chk("reset_err", err_o, 0);
        chk("reset_ax_valid", ax_valid_o, 0);
        rst_i = 1'b0;
        cycle();

        // Single burst of four beats.
        push_req(3);
        chk("len3_outstanding", outstanding_o, 1);
        hs_seen = 0;
        last_seen = 0;
        drain("len3_drained");
        chk("len3_beats", hs_seen, 4);
        chk("len3_lasts", last_seen, 1);

        // Fill to Depth, ninth request blocked until a pop lands.
        for (int i = 0; i < Depth; i++) push_req(0);
        ax_valid_i = 1'b1;
        ax_ready_i = 1'b1;
        ax_len_i   = 8'd0;
        #2;
        chk("ninth_blocked", ax_ready_o, 0);
        cycle();
        rsp_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        cycle();
        rsp_valid_i = 1'b0;
        #2;
        chk("ninth_ready_after_pop", ax_ready_o, 1);
        cycle();
        chk("ninth_accepted", outstanding_o, Depth);
        drain("full_drained");

        // Back-to-back len=1, len=0 with a toggling downstream ready.
        push_req(1);
        push_req(0);
        hs_seen = 0;
        last_seen = 0;
        rsp_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rsp_ready_i = i[0];
            cycle();
        end
        idle();
        chk("toggle_beats", hs_seen, 3);
        chk("toggle_lasts", last_seen, 2);
        chk("toggle_outstanding", outstanding_o, 0);

        // Push coinciding with a last-beat pop at two outstanding.
        push_req(0);
        push_req(1);
        ax_valid_i  = 1'b1;
        ax_ready_i  = 1'b1;
        ax_len_i    = 8'd2;
        rsp_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        cycle();
        idle();
        chk("push_pop_same_cycle", outstanding_o, 2);
        drain("push_pop_drained");

        // Stray beat while empty.
        rsp_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        #2;
        chk("stray_ready", rsp_ready_o, ErrEn);
        chk("stray_valid", rsp_valid_o, 0);
        cycle();
        idle();
        cycle();
        chk("stray_err", err_o, ErrEn);

        // Reset in the middle of beat 2 of a len=3 burst.
        push_req(3);
        rsp_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        cycle();
        #2;
        rst_i = 1'b1;
        #1;
        chk("midrst_outstanding", outstanding_o, 0);
        chk("midrst_rsp_valid", rsp_valid_o, 0);
        chk("midrst_rsp_last", rsp_last_o, 0);
        chk("midrst_err", err_o, 0);
        model_clear();
        idle();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        push_req(1);
        hs_seen = 0;
        last_seen = 0;
        drain("postrst_drained");
        chk("postrst_beats", hs_seen, 2);

        // Maximum length burst: 256 beats, counter must not overflow early.
        push_req(255);
        hs_seen = 0;
        last_seen = 0;
        drain("maxlen_drained");
        chk("maxlen_beats", hs_seen, 256);
        chk("maxlen_lasts", last_seen, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            ax_valid_i  = ($urandom_range(0, 99) < 50);
            ax_ready_i  = ($urandom_range(0, 99) < 70);
            ax_len_i    = ($urandom_range(0, 9) == 0) ? LenWidth'($urandom_range(4, 20))
                                                      : LenWidth'($urandom_range(0, 3));
            rsp_valid_i = ($urandom_range(0, 99) < 60);
            rsp_ready_i = ($urandom_range(0, 99) < 70);
            cycle();
        end
        drain("random_drained");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
